reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 register file. The register file has one write port. This block shares that port between two sources: the in-order pipeline writeback, which has fixed priority and cannot stall, and a long-latency result source (multiply/divide unit, late loads), which uses a valid/ready handshake backed by a small FIFO. It also tracks registers that have outstanding long-latency writes so the hazard unit can interlock on them. It sits between the WB stage / long-latency units and the register-file write port.

## Interface
- DEPTH, 2: secondary FIFO entries; power of two, ≥2.
- STARVE_MAX, 4: consecutive blocked cycles of a pending secondary write before stall_req asserts; ≥2.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pri_we  in  1  pipeline writeback request.
- pri_addr  in  5  pipeline destination register.
- pri_data  in  32  pipeline result.
- sec_valid  in  1  long-latency result valid.
- sec_ready  out  1  FIFO can accept; equals !full.
- sec_addr  in  5  long-latency destination register.
- sec_data  in  32  long-latency result.
- alloc_en  in  1  long-latency op issued; mark alloc_addr busy.
- alloc_addr  in  5  destination of the issued op.
- q_addr1, q_addr2  in  5 each  hazard query addresses.
- q_busy1, q_busy2  out  1 each  query address has an outstanding secondary write.
- stall_req  out  1  registered; requests a pipeline bubble so the secondary source can drain.
- REG_write_1  out  1  register-file write enable.
- REG_address_wr  out  5  register-file write address.
- REG_data_wb_in1  out  32  register-file write data.

## Operation
- Primary path:
  - pri_we=1 and pri_addr≠0 → write port driven combinationally from the pri_* inputs in the same cycle.
  - pri_addr=0 → the request is discarded and the port is treated as free.
- Secondary FIFO:
  - Push when sec_valid && sec_ready.
  - No push while full, even if a pop occurs in the same cycle.
  - Entries leave in FIFO order.
- Grant rule: the FIFO head is granted when the FIFO is non-empty and the port is free (no primary write this cycle). On grant, the head is popped at the cycle's edge.
- Head address 0:
  - The entry is popped whenever granted, with REG_write_1=0.
  - It is never written, because the register file's bypass would otherwise forward nonzero data for r0.
- REG_write_1 is never 1 with REG_address_wr=0. When idle: REG_write_1=0, and address/data are don't-care (driven 0).
- Scoreboard (32 busy bits):
  - Set: alloc_en sets busy[alloc_addr].
  - Clear: a granted head entry clears busy[head addr].
  - Same register set and cleared in one cycle: set wins.
  - Address 0 is never busy.
  - Primary writes do not touch the busy bits. Primary-vs-secondary write-after-write ordering is the hazard unit's responsibility.
- Query: q_busyN = busy[q_addrN], a combinational read of the registered bits. A clear becomes visible the cycle after commit.
- Starvation:
  - starve_cnt counts cycles in which the FIFO is non-empty and the head is not granted.
  - starve_cnt resets to 0 on a grant or when the FIFO is empty, and saturates at STARVE_MAX-1.
  - When blocked with starve_cnt==STARVE_MAX-1, stall_req is set at the edge.
  - stall_req clears at the edge of the cycle in which a grant occurs (or the FIFO is empty).
  - While stall_req=1 the pipeline must hold pri_we=0. If pri_we is asserted anyway, the primary still wins.
- Reset mid-operation: the FIFO is flushed (queued writes lost), all busy bits are cleared, starve_cnt and stall_req are cleared, and in-flight data is discarded.

## Timing
- Reset values: sec_ready=1, stall_req=0, q_busy1/2=0, REG_write_1=0, FIFO empty, all busy bits 0.
- While rst=1, REG_write_1 is forced to 0.
- Primary latency: 0 cycles (combinational pass-through).
- Secondary latency: an entry accepted in cycle t is earliest written in cycle t+1. There is no same-cycle bypass from sec_* to the port.
- sec_ready falls the cycle after the push that fills the FIFO, and rises the cycle after a pop from full.
- Alloc latency: alloc in cycle t → q_busy=1 from cycle t+1.
- Commit latency: commit in cycle t → q_busy=0 from cycle t+1, unless re-allocated.
- Stall latency: the earliest stall_req is STARVE_MAX+1 cycles after the push cycle.

## Test plan
- Reset: hold rst for 2 cycles with random inputs → REG_write_1=0, sec_ready=1, stall_req=0, all q_busy=0 on the first cycle after release.
- Primary pass-through:
  - pri_we=1, addr 5, data 0xDEADBEEF → same cycle REG_write_1=1, REG_address_wr=5, REG_data_wb_in1=0xDEADBEEF.
  - pri_addr=0 → REG_write_1=0.
- Alloc/commit:
  - Alloc r9 at cycle 0 → q_busy1(q_addr1=9)=1 at cycle 1.
  - Push {9, 0x1234} at cycle 3 with primary idle → write of r9=0x1234 at cycle 4; q_busy1=0 at cycle 5.
- Starvation (STARVE_MAX=4):
  - pri_we held high with addr 7; push one secondary entry at cycle 0 → no secondary write in cycles 1–4; stall_req=1 at cycle 5.
  - Drop pri_we at cycle 5 → secondary written at cycle 5; stall_req=0 at cycle 6.
- Full and ordering (DEPTH=2): primary busy, push A and B → sec_ready=0 at cycle 2; C is held on sec_valid. Release primary → writes A, B, C in order on consecutive cycles.
- Corner cases:
  - Alloc r3 in the same cycle r3 commits → busy stays 1.
  - Head addr 0 → popped with no write.
  - rst asserted with 2 entries queued → FIFO empty, no further writes.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: fixed-priority pipeline writeback, FIFO-backed
// long-latency source, pending-write scoreboard and starvation stall request.
module reg_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pri_we,
  input  logic [4:0]  pri_addr,
  input  logic [31:0] pri_data,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [4:0]  sec_addr,
  input  logic [31:0] sec_data,
  input  logic        alloc_en,
  input  logic [4:0]  alloc_addr,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        stall_req,
  output logic        REG_write_1,
  output logic [4:0]  REG_address_wr,
  output logic [31:0] REG_data_wb_in1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX);
  localparam logic [AW:0]   CountFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [CW-1:0] CntMax    = CW'(STARVE_MAX - 1);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   busy, busy_d;
  logic [CW-1:0] starve_cnt;

  logic empty, full, push, pop, pri_active, grant;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign empty      = (count == '0);
  assign full       = (count == CountFull);
  assign sec_ready  = !full;
  assign push       = sec_valid && !full;
  assign pri_active = pri_we && (pri_addr != 5'd0);
  assign grant      = !empty && !pri_active && !rst;
  assign pop        = grant;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sec_addr;
      fifo_data[wr_ptr] <= sec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
      case ({push, pop})
        2'b10:   count <= count + CountOne;
        2'b01:   count <= count - CountOne;
        default: count <= count;
      endcase
    end
  end

  // Allocation is applied after the commit clear so a same-cycle re-alloc wins.
  always_comb begin
    busy_d = busy;
    if (grant) busy_d[head_addr] = 1'b0;
    if (alloc_en) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  assign q_busy1 = busy[q_addr1];
  assign q_busy2 = busy[q_addr2];

  always_ff @(posedge clk) begin
    if (rst || empty || grant) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else if (starve_cnt == CntMax) begin
      stall_req  <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + CntOne;
    end
  end

  always_comb begin
    REG_write_1     = 1'b0;
    REG_address_wr  = 5'd0;
    REG_data_wb_in1 = 32'd0;
    if (rst) begin
      REG_write_1 = 1'b0;
    end else if (pri_active) begin
      REG_write_1     = 1'b1;
      REG_address_wr  = pri_addr;
      REG_data_wb_in1 = pri_data;
    end else if (grant && (head_addr != 5'd0)) begin
      REG_write_1     = 1'b1;
      REG_address_wr  = head_addr;
      REG_data_wb_in1 = head_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based model.
module tb_reg_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pri_we;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_busy1, q_busy2;
  logic        stall_req;
  logic        REG_write_1;
  logic [4:0]  REG_address_wr;
  logic [31:0] REG_data_wb_in1;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pri_we(pri_we), .pri_addr(pri_addr), .pri_data(pri_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .stall_req(stall_req), .REG_write_1(REG_write_1),
    .REG_address_wr(REG_address_wr), .REG_data_wb_in1(REG_data_wb_in1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   mbusy[32];
  int   mstarve;
  bit   mstall;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mstarve = 0;
    mstall = 1'b0;
  endtask

  // Called at negedge: compare DUT with the model, then advance the model across the edge.
  task automatic tick();
    bit pa, g, pu;
    bit ew;
    logic [4:0] ea;
    logic [31:0] ed;
    ent_t e;
    pa = pri_we && (pri_addr != 5'd0);
    g  = (mq.size() > 0) && !pa && !rst;
    ew = 1'b0; ea = '0; ed = '0;
    if (!rst && pa) begin
      ew = 1'b1; ea = pri_addr; ed = pri_data;
    end else if (g && mq[0].a != 5'd0) begin
      ew = 1'b1; ea = mq[0].a; ed = mq[0].d;
    end
    chk("m_we", {31'd0, REG_write_1}, {31'd0, ew});
    chk("m_waddr", {27'd0, REG_address_wr}, {27'd0, ea});
    chk("m_wdata", REG_data_wb_in1, ed);
    chk("m_ready", {31'd0, sec_ready}, {31'd0, mq.size() < DEPTH});
    chk("m_busy1", {31'd0, q_busy1}, {31'd0, mbusy[q_addr1]});
    chk("m_busy2", {31'd0, q_busy2}, {31'd0, mbusy[q_addr2]});
    chk("m_stall", {31'd0, stall_req}, {31'd0, mstall});
    pu = sec_valid && (mq.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (mq.size() == 0 || g) begin
        mstarve = 0;
        mstall = 1'b0;
      end else if (mstarve == STARVE_MAX - 1) begin
        mstall = 1'b1;
      end else begin
        mstarve++;
      end
      if (g) begin
        mbusy[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      if (alloc_en) mbusy[alloc_addr] = 1'b1;
      mbusy[0] = 1'b0;
      if (pu) begin
        e.a = sec_addr; e.d = sec_data;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic go();
    @(negedge clk);
  endtask

  task automatic idle();
    pri_we = 0; pri_addr = 0; pri_data = 0;
    sec_valid = 0; sec_addr = 0; sec_data = 0;
    alloc_en = 0; alloc_addr = 0; q_addr1 = 0; q_addr2 = 0;
  endtask

  task automatic rand_in();
    pri_we     = ($urandom_range(0, 3) != 0) && !(mstall && $urandom_range(0, 7) != 0);
    pri_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    pri_data   = $urandom;
    sec_valid  = $urandom_range(0, 1) == 1;
    sec_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    sec_data   = $urandom;
    alloc_en   = $urandom_range(0, 2) == 0;
    alloc_addr = 5'($urandom);
    q_addr1    = 5'($urandom);
    q_addr2    = 5'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in();
      go();
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;

    // Reset with random inputs
    do_reset();
    q_addr1 = 5'd9; q_addr2 = 5'd17;
    go();
    chk("rst_we", {31'd0, REG_write_1}, 32'd0);
    chk("rst_ready", {31'd0, sec_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_busy", {30'd0, q_busy1, q_busy2}, 32'd0);
    tick();

    // Primary pass-through
    pri_we = 1; pri_addr = 5'd5; pri_data = 32'hDEADBEEF;
    go();
    chk("pri_we", {31'd0, REG_write_1}, 32'd1);
    chk("pri_addr", {27'd0, REG_address_wr}, 32'd5);
    chk("pri_data", REG_data_wb_in1, 32'hDEADBEEF);
    tick();
    pri_addr = 5'd0;
    go();
    chk("pri_r0", {31'd0, REG_write_1}, 32'd0);
    tick();
    idle();

    // Alloc then commit
    alloc_en = 1; alloc_addr = 5'd9; q_addr1 = 5'd9;
    go(); tick();
    alloc_en = 0;
    go(); chk("alloc_busy", {31'd0, q_busy1}, 32'd1); tick();
    go(); tick();
    sec_valid = 1; sec_addr = 5'd9; sec_data = 32'h1234;
    go(); tick();
    sec_valid = 0;
    go();
    chk("commit_we", {31'd0, REG_write_1}, 32'd1);
    chk("commit_addr", {27'd0, REG_address_wr}, 32'd9);
    chk("commit_data", REG_data_wb_in1, 32'h1234);
    chk("commit_busy_c4", {31'd0, q_busy1}, 32'd1);
    tick();
    go(); chk("commit_clear", {31'd0, q_busy1}, 32'd0); tick();

    // Starvation
    do_reset();
    pri_we = 1; pri_addr = 5'd7; pri_data = 32'h77;
    sec_valid = 1; sec_addr = 5'd12; sec_data = 32'h00C0FFEE;
    go(); tick();
    sec_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      go();
      chk("starve_hold_addr", {27'd0, REG_address_wr}, 32'd7);
      chk("starve_no_stall", {31'd0, stall_req}, 32'd0);
      tick();
    end
    pri_we = 0;
    go();
    chk("starve_stall", {31'd0, stall_req}, 32'd1);
    chk("starve_drain", {27'd0, REG_address_wr}, 32'd12);
    chk("starve_drain_we", {31'd0, REG_write_1}, 32'd1);
    tick();
    go(); chk("starve_release", {31'd0, stall_req}, 32'd0); tick();

    // Full and ordering
    do_reset();
    pri_we = 1; pri_addr = 5'd7; pri_data = 32'h7;
    sec_valid = 1; sec_addr = 5'd1; sec_data = 32'hA;
    go(); tick();
    sec_addr = 5'd2; sec_data = 32'hB;
    go(); tick();
    sec_addr = 5'd3; sec_data = 32'hC;
    go(); chk("full_ready", {31'd0, sec_ready}, 32'd0); tick();
    pri_we = 0;
    go();
    chk("ord_a", {27'd0, REG_address_wr}, 32'd1);
    chk("ord_a_data", REG_data_wb_in1, 32'hA);
    tick();
    go();
    chk("ord_b", {27'd0, REG_address_wr}, 32'd2);
    chk("ord_ready_back", {31'd0, sec_ready}, 32'd1);
    tick();
    sec_valid = 0;
    go();
    chk("ord_c", {27'd0, REG_address_wr}, 32'd3);
    chk("ord_c_data", REG_data_wb_in1, 32'hC);
    tick();
    go(); chk("ord_idle", {31'd0, REG_write_1}, 32'd0); tick();

    // Same-cycle alloc and commit of r3
    do_reset();
    alloc_en = 1; alloc_addr = 5'd3; q_addr1 = 5'd3;
    go(); tick();
    alloc_en = 0; sec_valid = 1; sec_addr = 5'd3; sec_data = 32'h33;
    go(); tick();
    sec_valid = 0; alloc_en = 1;
    go(); chk("realloc_commit", {27'd0, REG_address_wr}, 32'd3); tick();
    alloc_en = 0;
    go(); chk("realloc_busy", {31'd0, q_busy1}, 32'd1); tick();

    // Head address 0
    sec_valid = 1; sec_addr = 5'd0; sec_data = 32'hAAAA;
    go(); tick();
    sec_valid = 0;
    go(); chk("r0_nowrite", {31'd0, REG_write_1}, 32'd0); tick();

    // Reset with entries queued
    pri_we = 1; pri_addr = 5'd7;
    sec_valid = 1; sec_addr = 5'd4; sec_data = 32'h44;
    go(); tick();
    sec_addr = 5'd6; sec_data = 32'h66;
    go(); tick();
    sec_valid = 0; rst = 1;
    go(); tick();
    rst = 0; pri_we = 0;
    for (int c = 0; c < 3; c++) begin
      go();
      chk("flush_nowrite", {31'd0, REG_write_1}, 32'd0);
      chk("flush_ready", {31'd0, sec_ready}, 32'd1);
      tick();
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rand_in();
      rst = ($urandom_range(0, 299) == 0);
      go();
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
